fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues reads to the instruction memory over a Rd/Stall/Done handshake. It also forms the IF/ID pipeline register that supplies decode with `instr`, `pcPlus2` and `valid`. It absorbs variable memory latency, decode-side stalls, execute-side redirects (branch/jump) and HALT.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP`, 16'h0800, instruction word driven when the IF/ID slot is empty or flushed.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode hazard stall; IF/ID contents must hold.
- `redirect`  in  1  branch/jump taken; flush and refetch from `redirectPC`.
- `redirectPC`  in  16  redirect target, valid when `redirect`=1.
- `memAddr`  out  16  instruction address; always equals the PC register.
- `memRd`  out  1  one-cycle read request.
- `memStall`  in  1  memory busy; no request may be issued while it is high.
- `memDone`  in  1  one-cycle pulse; `memDataOut` is valid in that cycle.
- `memDataOut`  in  16  returned instruction word.
- `instr`  out  16  IF/ID instruction to decode.
- `pcPlus2`  out  16  IF/ID address of the instruction plus 2.
- `valid`  out  1  IF/ID slot holds a real instruction.
- `halted`  out  1  high while in HALTED.

## Operation
- States: FETCH, WAIT, HOLD, DISCARD, HALTED.
- `memRd` = (state==FETCH) & !stall & !redirect & !memStall. This is combinational.
- A **deliver** action loads `instr`<=word, `pcPlus2`<=pc+2, `valid`<=1 and pc<=pc+2. PC arithmetic is modulo 2^16, so 16'hFFFE+2 = 16'h0000.
- After a deliver, the next state is HALTED if word[15:11]==5'b00000. Otherwise it is FETCH.
- **FETCH** transitions:
  - `redirect`: pc<=`redirectPC`, stay in FETCH.
  - `memRd` & `memDone` in the same cycle (hit): deliver.
  - `memRd` alone: go to WAIT.
- **WAIT** transitions:
  - `redirect` & `memDone`: drop the word, pc<=target, go to FETCH.
  - `redirect` alone: pc<=target, go to DISCARD.
  - `memDone` & `stall`: latch the word into the hold buffer, go to HOLD.
  - `memDone` alone: deliver.
- **HOLD** transitions:
  - `redirect`: drop the buffer, pc<=target, go to FETCH.
  - `!stall`: deliver the buffered word.
- **DISCARD**:
  - Waits for the abandoned request's `memDone`; that word is never delivered. Then go to FETCH.
  - A further `redirect` while in DISCARD overwrites pc (latest wins).
- **HALTED**:
  - No requests are issued.
  - `redirect` sets pc<=target and returns to FETCH, so a wrong-path HALT is squashed.
  - Otherwise HALTED persists until `rst`.
- **IF/ID update priority** (highest first):
  1. `redirect`: `instr`<=NOP, `valid`<=0.
  2. deliver.
  3. `stall`: hold all IF/ID outputs.
  4. otherwise: `instr`<=NOP, `valid`<=0.

## Timing
- **Reset** (synchronous):
  - pc=`RESET_PC`, state=FETCH.
  - `instr`=NOP, `pcPlus2`=0, `valid`=0, `halted`=0, hold buffer cleared.
  - `memRd` is 0 during the reset cycle.
- Reset asserted mid-request (WAIT/DISCARD) abandons the request. A `memDone` arriving after reset while in FETCH with no request issued is ignored.
- **Latency:**
  - Hit (Done in the same cycle as Rd): `instr` valid on the next edge, so one instruction per cycle.
  - Miss: `instr` valid on the edge after `memDone`.
- **Redirect:** the first request to `redirectPC` is issued the cycle after `redirect` from FETCH/HOLD/HALTED, or the cycle after `memDone` from DISCARD.
- **Simultaneous events:**
  - `redirect` beats `stall` and beats `memDone`.
  - `stall` with a returning word buffers it and never drops it.
  - `memStall` only delays issue and never changes state.
- At most one outstanding request at any time.

## Test plan
- **Reset then hit stream:** `rst` 1 cycle; memory hits with words A,B,C at 0,2,4. `memRd` high each cycle; `instr` = A,B,C on consecutive edges with `pcPlus2` = 2,4,6 and `valid`=1.
- **Miss with stall at return:** request at 0; `memDone` 3 cycles later while `stall`=1 for 2 more cycles. `valid`/`instr` hold their old values; the word appears the edge after `stall` drops; pc=2.
- **Redirect during miss:** in WAIT at pc=0, `redirect`=1 with `redirectPC`=16'h0040. DISCARD; the late `memDone` word is never visible; the next `memAddr`=0x0040; `valid`=0 meanwhile.
- **Redirect+stall+Done same cycle:** `instr`=NOP, `valid`=0; pc=target; no HOLD entry.
- **HALT:** fetch word 16'h0000 at pc=6. Delivered once with `pcPlus2`=8; `halted`=1; no further `memRd`. A later `redirect` to 0x0010 resumes fetch.
- **Wrap:** `RESET_PC`=16'hFFFE with a hit. `pcPlus2`=0 and the next `memAddr`=16'h0000.

Source files
------------

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues Rd/Stall/Done reads to instruction
// memory and forms the IF/ID register presented to decode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | ready to issue a read at pc (hit delivers immediately)
// WAIT    | one read outstanding, waiting for memDone
// HOLD    | returned word buffered while decode is stalled
// DISCARD | redirected mid-read; swallow the stale memDone
// HALTED  | HALT delivered; idle until redirect or reset
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  output logic [15:0] memAddr,
  output logic        memRd,
  input  logic        memStall,
  input  logic        memDone,
  input  logic [15:0] memDataOut,
  output logic [15:0] instr,
  output logic [15:0] pcPlus2,
  output logic        valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DISCARD,
    S_HALTED
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] hold_buf;
  logic        deliver;
  logic [15:0] word;
  logic [15:0] pc_next_seq;

  assign memAddr     = pc;
  assign halted      = (state == S_HALTED);
  assign pc_next_seq = pc + 16'd2;
  // Reset gates the request so nothing is issued during the reset cycle.
  assign memRd = (state == S_FETCH) & ~stall & ~redirect & ~memStall & ~rst;

  always_comb begin
    deliver = 1'b0;
    word    = memDataOut;
    case (state)
      S_FETCH: deliver = memRd & memDone;
      S_WAIT:  deliver = ~redirect & memDone & ~stall;
      S_HOLD: begin
        deliver = ~redirect & ~stall;
        word    = hold_buf;
      end
      default: deliver = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      hold_buf <= 16'h0000;
      instr    <= NOP;
      pcPlus2  <= 16'h0000;
      valid    <= 1'b0;
    end else begin
      if (redirect) begin
        instr <= NOP;
        valid <= 1'b0;
      end else if (deliver) begin
        instr   <= word;
        pcPlus2 <= pc_next_seq;
        valid   <= 1'b1;
      end else if (!stall) begin
        instr <= NOP;
        valid <= 1'b0;
      end

      if (redirect) pc <= redirectPC;
      else if (deliver) pc <= pc_next_seq;

      case (state)
        S_FETCH: begin
          if (deliver) state <= (word[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
          else if (memRd) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect) state <= memDone ? S_FETCH : S_DISCARD;
          else if (memDone && stall) begin
            hold_buf <= memDataOut;
            state    <= S_HOLD;
          end else if (deliver) state <= (word[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
        end
        S_HOLD: begin
          if (redirect) state <= S_FETCH;
          else if (deliver) state <= (word[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
        end
        S_DISCARD: begin
          if (memDone) state <= S_FETCH;
        end
        S_HALTED: begin
          if (redirect) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: hits, misses with stall, redirects, HALT and PC wrap.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, memStall, memDone;
  logic [15:0] redirectPC, memDataOut;
  logic [15:0] memAddr, instr, pcPlus2;
  logic        memRd, valid, halted;
  logic [15:0] memAddr2, instr2, pcPlus22;
  logic        memRd2, valid2, halted2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] NOP = 16'h0800;

  always #5 clk = ~clk;

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .memAddr(memAddr), .memRd(memRd), .memStall(memStall), .memDone(memDone),
    .memDataOut(memDataOut), .instr(instr), .pcPlus2(pcPlus2), .valid(valid), .halted(halted)
  );

  fetch #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .memAddr(memAddr2), .memRd(memRd2), .memStall(memStall), .memDone(memDone),
    .memDataOut(memDataOut), .instr(instr2), .pcPlus2(pcPlus22), .valid(valid2), .halted(halted2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect = 0; redirectPC = 0; memStall = 0; memDone = 0; memDataOut = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    n_checks++; if (memRd !== 1'b0) begin n_fail++; $display("FAIL reset_memrd: got %b exp 0", memRd); end
    step();
    rst = 0;
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h exp %h", instr, NOP); end
    n_checks++; if (pcPlus2 !== 16'h0000) begin n_fail++; $display("FAIL reset_pcplus2: got %h exp 0000", pcPlus2); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b exp 0", halted); end
    n_checks++; if (memAddr !== 16'h0000) begin n_fail++; $display("FAIL reset_memaddr: got %h exp 0000", memAddr); end
    // memStall blocks issue; an unsolicited memDone must be ignored
    memStall = 1; memDone = 1; memDataOut = 16'h1357;
    #1;
    n_checks++; if (memRd !== 1'b0) begin n_fail++; $display("FAIL memstall_memrd: got %b exp 0", memRd); end
    step();
    idle_inputs();
    n_checks++; if (valid !== 1'b0 || memAddr !== 16'h0000) begin
      n_fail++; $display("FAIL stray_done: valid %b addr %h exp 0 0000", valid, memAddr);
    end
    #1;
    n_checks++; if (memRd !== 1'b1) begin n_fail++; $display("FAIL memstall_release: got %b exp 1", memRd); end
  endtask

  task automatic test_hit_stream();
    logic [15:0] words [3];
    words[0] = 16'h1A01; words[1] = 16'h2B02; words[2] = 16'h3C03;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      memDone = 1; memDataOut = words[i];
      #1;
      n_checks++; if (memRd !== 1'b1 || memAddr !== 16'(2*i)) begin
        n_fail++; $display("FAIL hit_issue%0d: rd %b addr %h exp 1 %h", i, memRd, memAddr, 16'(2*i));
      end
      step();
      n_checks++; if (instr !== words[i] || pcPlus2 !== 16'(2*i+2) || valid !== 1'b1) begin
        n_fail++; $display("FAIL hit_deliver%0d: instr %h pc2 %h v %b exp %h %h 1", i, instr, pcPlus2, valid, words[i], 16'(2*i+2));
      end
    end
    idle_inputs();
  endtask

  task automatic test_miss_stall();
    do_reset();
    #1;
    n_checks++; if (memRd !== 1'b1) begin n_fail++; $display("FAIL miss_issue: got %b exp 1", memRd); end
    step();
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (memRd !== 1'b0) begin n_fail++; $display("FAIL miss_wait_rd%0d: got %b exp 0", i, memRd); end
      step();
    end
    stall = 1; memDone = 1; memDataOut = 16'h4D04;
    step();
    memDone = 0; memDataOut = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (valid !== 1'b0 || instr !== NOP || memRd !== 1'b0) begin
        n_fail++; $display("FAIL miss_hold%0d: v %b instr %h rd %b exp 0 %h 0", i, valid, instr, memRd, NOP);
      end
      step();
    end
    stall = 0;
    step();
    n_checks++; if (instr !== 16'h4D04 || valid !== 1'b1 || pcPlus2 !== 16'h0002 || memAddr !== 16'h0002) begin
      n_fail++; $display("FAIL miss_release: instr %h v %b pc2 %h addr %h exp 4d04 1 0002 0002", instr, valid, pcPlus2, memAddr);
    end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    step();
    redirect = 1; redirectPC = 16'h0040;
    step();
    redirect = 0; redirectPC = 16'h0000;
    #1;
    n_checks++; if (valid !== 1'b0 || memAddr !== 16'h0040 || memRd !== 1'b0) begin
      n_fail++; $display("FAIL discard_enter: v %b addr %h rd %b exp 0 0040 0", valid, memAddr, memRd);
    end
    step();
    memDone = 1; memDataOut = 16'h5E05;
    #1;
    n_checks++; if (memRd !== 1'b0) begin n_fail++; $display("FAIL discard_rd: got %b exp 0", memRd); end
    step();
    memDone = 0;
    #1;
    n_checks++; if (valid !== 1'b0 || instr !== NOP || memRd !== 1'b1 || memAddr !== 16'h0040) begin
      n_fail++; $display("FAIL discard_exit: v %b instr %h rd %b addr %h exp 0 %h 1 0040", valid, instr, memRd, memAddr, NOP);
    end
    memDone = 1; memDataOut = 16'h6F06;
    step();
    memDone = 0;
    n_checks++; if (instr !== 16'h6F06 || pcPlus2 !== 16'h0042 || valid !== 1'b1) begin
      n_fail++; $display("FAIL redirect_refetch: instr %h pc2 %h v %b exp 6f06 0042 1", instr, pcPlus2, valid);
    end
  endtask

  task automatic test_redirect_stall_done();
    do_reset();
    step();
    redirect = 1; stall = 1; memDone = 1; redirectPC = 16'h0080; memDataOut = 16'h7007;
    step();
    idle_inputs();
    #1;
    n_checks++; if (instr !== NOP || valid !== 1'b0 || memAddr !== 16'h0080 || memRd !== 1'b1) begin
      n_fail++; $display("FAIL redir_stall_done: instr %h v %b addr %h rd %b exp %h 0 0080 1", instr, valid, memAddr, memRd, NOP);
    end
  endtask

  task automatic test_halt();
    logic [15:0] words [4];
    words[0] = 16'h1A01; words[1] = 16'h2B02; words[2] = 16'h3C03; words[3] = 16'h0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      memDone = 1; memDataOut = words[i];
      step();
    end
    memDone = 0;
    n_checks++; if (instr !== 16'h0000 || pcPlus2 !== 16'h0008 || valid !== 1'b1 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_deliver: instr %h pc2 %h v %b h %b exp 0000 0008 1 1", instr, pcPlus2, valid, halted);
    end
    n_checks++; if (memRd !== 1'b0) begin n_fail++; $display("FAIL halt_no_rd: got %b exp 0", memRd); end
    step();
    n_checks++; if (valid !== 1'b0 || halted !== 1'b1 || memRd !== 1'b0) begin
      n_fail++; $display("FAIL halt_idle: v %b h %b rd %b exp 0 1 0", valid, halted, memRd);
    end
    redirect = 1; redirectPC = 16'h0010;
    step();
    idle_inputs();
    #1;
    n_checks++; if (halted !== 1'b0 || memAddr !== 16'h0010 || memRd !== 1'b1) begin
      n_fail++; $display("FAIL halt_resume: h %b addr %h rd %b exp 0 0010 1", halted, memAddr, memRd);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    n_checks++; if (memAddr2 !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_reset_pc: got %h exp fffe", memAddr2); end
    memDone = 1; memDataOut = 16'h1234;
    step();
    memDone = 0;
    n_checks++; if (pcPlus22 !== 16'h0000 || memAddr2 !== 16'h0000 || instr2 !== 16'h1234 || valid2 !== 1'b1) begin
      n_fail++; $display("FAIL wrap: pc2 %h addr %h instr %h v %b exp 0000 0000 1234 1", pcPlus22, memAddr2, instr2, valid2);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_hit_stream();
    test_miss_stall();
    test_redirect_miss();
    test_redirect_stall_done();
    test_halt();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
